// File: rtl/rls_pkg.sv
// Shared types and arithmetic helpers for the RLS datapath blocks.
package rls_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_WAIT = 2'd1,
        MAC      = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;

    // Fixed-point multiply on sign-extended operands (element width <= 64).
    // The caller keeps the low element-width bits, so the result wraps.
    // The arithmetic shift truncates toward -inf; no rounding is applied.
    function automatic logic signed [127:0] fxmul_wide(input logic signed [63:0] a,
                                                       input logic signed [63:0] b,
                                                       input int unsigned frac);
        logic signed [127:0] p;
        p = 128'(a) * 128'(b);
        return p >>> frac;
    endfunction

endpackage

// File: rtl/dot_chunk_mac.sv
// One reduction step: COMBSIZE fixed-point lane products summed onto the running accumulator.
module dot_chunk_mac
    import rls_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int COMBSIZE = 4,
    parameter int FRAC     = DEF_FRAC
) (
    input  logic        [WIDTH*COMBSIZE-1:0] row_chunk,
    input  logic        [WIDTH*COMBSIZE-1:0] x_chunk,
    input  logic signed [WIDTH-1:0]          acc_in,
    output logic signed [WIDTH-1:0]          acc_out
);

    logic signed [WIDTH-1:0] lane_prod;
    logic signed [WIDTH-1:0] lane_sum;

    // Lane products and their sum; every addition wraps modulo 2^WIDTH.
    always_comb begin
        lane_prod = '0;
        lane_sum  = '0;
        for (int j = 0; j < COMBSIZE; j++) begin
            lane_prod = WIDTH'(fxmul_wide(64'(signed'(row_chunk[WIDTH*j +: WIDTH])),
                                          64'(signed'(x_chunk[WIDTH*j +: WIDTH])),
                                          FRAC));
            lane_sum  = lane_sum + lane_prod;
        end
        acc_out = acc_in + lane_sum;
    end

endmodule

// File: rtl/matvec_row_sequencer.sv
// Row-streaming matrix-vector product y = P*x for the RLS update.
// x is captured on start, each row of P is accepted by handshake and reduced
// COMBSIZE lanes per cycle into one element of y_out.
module matvec_row_sequencer
    import rls_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               SIZE        = 16,
    parameter int               ROWS        = 16,
    parameter int               COMBSIZE    = 4,
    parameter int               FRAC        = DEF_FRAC,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH*SIZE-1:0] x_in,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [WIDTH*SIZE-1:0] row_data,
    output logic [WIDTH*ROWS-1:0] y_out,
    output logic                  y_valid,
    output logic                  busy
);

    localparam int NCHUNK = SIZE / COMBSIZE;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = WIDTH * COMBSIZE;

    state_t                  state, state_next;
    logic [RW-1:0]           row_cnt;
    logic [KW-1:0]           k_cnt;
    logic [WIDTH*SIZE-1:0]   x_reg;
    logic [WIDTH*SIZE-1:0]   row_reg;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] acc_next;
    logic                    last_chunk;
    logic                    last_row;

    assign last_chunk = (k_cnt == KW'(NCHUNK - 1));
    assign last_row   = (row_cnt == RW'(ROWS - 1));

    dot_chunk_mac #(
        .WIDTH   (WIDTH),
        .COMBSIZE(COMBSIZE),
        .FRAC    (FRAC)
    ) u_mac (
        .row_chunk(row_reg[CW*k_cnt +: CW]),
        .x_chunk  (x_reg[CW*k_cnt +: CW]),
        .acc_in   (acc),
        .acc_out  (acc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and state-decoded outputs; row_ready depends on state only.
    always_comb begin
        state_next = state;
        row_ready  = 1'b0;
        y_valid    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = ROW_WAIT;
            end
            ROW_WAIT: begin
                row_ready = 1'b1;
                if (row_valid) state_next = MAC;
            end
            MAC: begin
                if (last_chunk) state_next = last_row ? DONE : ROW_WAIT;
            end
            DONE: begin
                y_valid    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture: x on an accepted start, a row on each accepted handshake.
    always_ff @(posedge clk) begin
        if (state == IDLE && start)        x_reg   <= x_in;
        if (state == ROW_WAIT && row_valid) row_reg <= row_data;
    end

    // Counters, accumulator and result file; reset clears any partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
            k_cnt   <= '0;
            acc     <= RESET_VALUE;
            y_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) row_cnt <= '0;
                end
                ROW_WAIT: begin
                    if (row_valid) begin
                        k_cnt <= '0;
                        acc   <= RESET_VALUE;
                    end
                end
                MAC: begin
                    acc   <= acc_next;
                    k_cnt <= k_cnt + 1'b1;
                    if (last_chunk) begin
                        y_out[WIDTH*row_cnt +: WIDTH] <= acc_next;
                        if (!last_row) row_cnt <= row_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_row_sequencer.sv
// Directed bench for matvec_row_sequencer with a plain-arithmetic reference model.
module tb_matvec_row_sequencer;

    localparam int W   = 32;
    localparam int S   = 16;
    localparam int R   = 16;
    localparam int CS  = 4;
    localparam int NCH = S / CS;
    localparam int LAT = 1 + R * (1 + NCH);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W*S-1:0] x_in = '0;
    logic           row_valid = 1'b0;
    logic           row_ready;
    logic [W*S-1:0] row_data = '0;
    logic [W*R-1:0] y_out;
    logic           y_valid;
    logic           busy;

    matvec_row_sequencer #(
        .WIDTH(W), .SIZE(S), .ROWS(R), .COMBSIZE(CS), .FRAC(16), .RESET_VALUE('0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .y_out(y_out), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_total = 0;
    int          hs_base = 0;
    int          P [R][S];
    int          xv [S];
    logic [511:0] exp_y;
    logic [511:0] last_y = '0;
    int          exp_lat = 0;
    int          start_cyc = 0;
    bit          op_active = 1'b0;
    bit          drive_rows = 1'b0;
    int          stall_row = -1;
    int          stall_left = 0;
    bit          stalling = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: y_r = RESET_VALUE + sum_j trunc32((P[r][j]*x[j]) >>> 16), wrapping mod 2^32.
    function automatic logic [511:0] model();
        logic [511:0] y;
        y = '0;
        for (int r = 0; r < R; r++) begin
            int acc;
            acc = 0;
            for (int j = 0; j < S; j++) begin
                longint pr;
                pr  = (longint'(P[r][j]) * longint'(xv[j])) >>> 16;
                acc = acc + int'(pr);
            end
            y[32*r +: 32] = acc;
        end
        return y;
    endfunction

    function automatic logic [511:0] pack_x();
        logic [511:0] v;
        for (int i = 0; i < S; i++) v[32*i +: 32] = xv[i];
        return v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (row_valid && row_ready) hs_total <= hs_total + 1;
    end

    // Row source: presents the next unaccepted row, optionally stalling before one row.
    always @(negedge clk) begin
        int idx;
        idx = hs_total - hs_base;
        if (idx >= 0 && idx < R)
            for (int j = 0; j < S; j++) row_data[32*j +: 32] = P[idx][j];
        if (!stalling && stall_left > 0 && idx == stall_row && row_ready) stalling = 1'b1;
        if (stalling) begin
            chk32("row_ready_during_stall", 32'(row_ready), 32'd1);
            row_valid = 1'b0;
            stall_left--;
            if (stall_left == 0) stalling = 1'b0;
        end else begin
            row_valid = drive_rows;
        end
    end

    // Result checker: every y_valid must match an expected operation, its latency and its data.
    always @(negedge clk) begin
        if (y_valid) begin
            chk32("y_valid_expected", 32'(op_active), 32'd1);
            if (op_active) begin
                chk32("latency", 32'(cyc - start_cyc + 1), 32'(exp_lat));
                chk("y_out_model", y_out, exp_y);
                last_y = y_out;
            end
            op_active = 1'b0;
        end else if (op_active && (cyc - start_cyc + 1) > exp_lat) begin
            checks++;
            errors++;
            $display("FAIL y_valid_late actual=none required=cycle %0d", exp_lat);
            op_active = 1'b0;
        end
    end

    task automatic run_op(input int lat);
        @(negedge clk);
        x_in      = pack_x();
        hs_base   = hs_total;
        exp_y     = model();
        exp_lat   = lat;
        start_cyc = cyc + 1;
        op_active = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && op_active; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic fill(input int pv, input bit ident);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < S; j++)
                P[r][j] = ident ? ((r == j) ? 32'h0001_0000 : 0) : pv;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_y_out", 512'(y_out), '0);
        chk32("reset_busy", 32'(busy), 32'd0);
        chk32("reset_row_ready", 32'(row_ready), 32'd0);
        chk32("reset_y_valid", 32'(y_valid), 32'd0);
        reset = 1'b0;
        drive_rows = 1'b1;

        // 1: identity P
        fill(0, 1'b1);
        for (int i = 0; i < S; i++) xv[i] = 32'h0001_0000 * i;
        run_op(LAT);
        wait_done();
        chk("t1_identity", last_y, pack_x());
        chk32("t1_busy_after", 32'(busy), 32'd0);

        // 2: all 2.0 times all 3.0; x_in scrambled after capture
        fill(32'h0002_0000, 1'b0);
        for (int i = 0; i < S; i++) xv[i] = 32'h0003_0000;
        run_op(LAT);
        repeat (3) @(negedge clk);
        x_in = {16{32'hDEAD_BEEF}};
        wait_done();
        chk32("t2_y0", last_y[31:0], 32'h0060_0000);
        chk32("t2_y15", last_y[511:480], 32'h0060_0000);

        // 3: negative fractional products
        fill(32'hFFFE_8000, 1'b0);
        for (int i = 0; i < S; i++) xv[i] = 32'h0000_8000;
        run_op(LAT);
        wait_done();
        chk32("t3_y5", last_y[191:160], 32'hFFF4_0000);

        // 4: large products wrapping mod 2^32
        fill(32'h7FFF_0000, 1'b0);
        for (int i = 0; i < S; i++) xv[i] = 32'h7FFF_0000;
        run_op(LAT);
        wait_done();
        chk32("t4_y0", last_y[31:0], 32'h0010_0000);

        // 5: stall 5 cycles before row 3, start pulsed mid-run
        fill(0, 1'b1);
        for (int i = 0; i < S; i++) xv[i] = (i - 8) * 32'h0001_8000;
        stall_row  = 3;
        stall_left = 5;
        run_op(LAT + 5);
        repeat (20) @(negedge clk);
        start = 1'b1;
        x_in  = '1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("t5_identity", last_y, pack_x());
        chk32("t5_stall_used", 32'(stall_left), 32'd0);
        stall_row = -1;

        // 6: reset during MAC of row 7, then a clean run
        for (int i = 0; i < S; i++) xv[i] = 32'h0000_1000 * (i + 1);
        run_op(LAT);
        for (int i = 0; i < 200 && (hs_total - hs_base) < 8; i++) @(negedge clk);
        chk32("t6_busy_before_reset", 32'(busy), 32'd1);
        op_active = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_y_out_cleared", 512'(y_out), '0);
        chk32("t6_busy", 32'(busy), 32'd0);
        chk32("t6_y_valid", 32'(y_valid), 32'd0);
        chk32("t6_row_ready", 32'(row_ready), 32'd0);
        repeat (90) @(negedge clk);
        for (int i = 0; i < S; i++) xv[i] = -32'sh0000_4000 * i;
        run_op(LAT);
        wait_done();
        chk("t6_rerun", last_y, pack_x());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
